// File: rtl/stage_seq_pkg.sv
// Shared state encoding, timepulse bit positions and per-opcode order table
// for the stage sequencer.
package stage_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   localparam int TP1_B  = 0;
   localparam int TP2_B  = 1;
   localparam int TP3_B  = 2;
   localparam int TP4_B  = 3;
   localparam int TP5_B  = 4;
   localparam int TP6_B  = 5;
   localparam int TP7_B  = 6;
   localparam int TP8_B  = 7;
   localparam int TP9_B  = 8;
   localparam int TP10_B = 9;

   // Number of MCTs each opcode occupies.
   function automatic logic [2:0] STG_N(input logic [2:0] op);
      case (op)
         3'd1:    return 3'd2;
         3'd4:    return 3'd2;
         3'd5:    return 3'd3;
         3'd6:    return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   // Opcodes that write memory back in their final MCT.
   function automatic logic STG_WR(input logic [2:0] op);
      return (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
   endfunction

   function automatic logic [1:0] last_stage(input logic [2:0] op);
      logic [2:0] n;
      n = STG_N(op) - 3'd1;
      return n[1:0];
   endfunction

endpackage

// File: rtl/tp_checker.sv
// Timepulse sanity: flags multi-hot tp combinationally; optional stall watchdog (STAGE_SEQ_WATCHDOG_EN).
// wd_expire fires on the WD_LIMIT-th consecutive empty sample while run is high.
// No backpressure; purely observes tp.
module tp_checker #(
   parameter int WD_LIMIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] tp,
   input  logic       run,
   output logic       tp_multi,
   output logic       wd_expire
);

   assign tp_multi = |(tp & (tp - 10'd1));

`ifdef STAGE_SEQ_WATCHDOG_EN
   localparam int CW = $clog2(WD_LIMIT + 1);

   logic [CW-1:0] wd_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (!run || (tp != 10'd0)) begin
         wd_cnt <= '0;
      end else if (wd_cnt != CW'(WD_LIMIT)) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign wd_expire = run && (tp == 10'd0) && (wd_cnt == CW'(WD_LIMIT - 1));
`else
   logic unused_wd;
   assign unused_wd = clk & rst & run & (WD_LIMIT != 0);
   assign wd_expire = 1'b0;
`endif

endmodule

// File: rtl/stage_sequencer.sv
// Turns one-hot TP1-TP10 timepulses into per-instruction stage tracking and memory/ALU strobes.
// All outputs registered: a TP sampled at edge N shows its effect during cycle N+1.
// order_valid is held by the source until order_ack; only TP1 in IDLE accepts it.
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int MCT_W    = 8,
   parameter int WD_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       tp,
   input  logic [2:0]       order_code,
   input  logic             order_valid,
   output logic             order_ack,
   output logic [1:0]       stage,
   output logic             busy,
   output logic             rd_mem,
   output logic             alu_strobe,
   output logic             wr_mem,
   output logic             instr_done,
   output logic [MCT_W-1:0] mct_count,
   output logic             tp_err
);

   state_t     state;
   logic [2:0] op;
   logic       tp_multi;
   logic       wd_expire;
   logic       run;
   logic       at_last;

   assign run     = (state == RUN);
   assign at_last = (stage == last_stage(op));

   tp_checker #(.WD_LIMIT(WD_LIMIT)) u_tp_checker (
      .clk       (clk),
      .rst       (rst),
      .tp        (tp),
      .run       (run),
      .tp_multi  (tp_multi),
      .wd_expire (wd_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         op         <= 3'd0;
         stage      <= 2'd0;
         busy       <= 1'b0;
         order_ack  <= 1'b0;
         rd_mem     <= 1'b0;
         alu_strobe <= 1'b0;
         wr_mem     <= 1'b0;
         instr_done <= 1'b0;
         mct_count  <= '0;
         tp_err     <= 1'b0;
      end else begin
         order_ack  <= 1'b0;
         rd_mem     <= 1'b0;
         alu_strobe <= 1'b0;
         wr_mem     <= 1'b0;
         instr_done <= 1'b0;

         // A malformed multi-hot word never counts as an MCT boundary.
         if ((state != ERR) && tp[TP10_B] && !tp_multi) begin
            mct_count <= mct_count + 1'b1;
         end

         case (state)
            IDLE: begin
               if (tp_multi) begin
                  state  <= ERR;
                  tp_err <= 1'b1;
                  busy   <= 1'b0;
               end else if (tp[TP1_B] && order_valid) begin
                  op        <= order_code;
                  order_ack <= 1'b1;
                  stage     <= 2'd0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (tp_multi || wd_expire) begin
                  state  <= ERR;
                  tp_err <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  rd_mem     <= tp[TP2_B];
                  alu_strobe <= tp[TP5_B];
                  wr_mem     <= tp[TP8_B] && STG_WR(op) && at_last;
                  if (tp[TP10_B]) begin
                     if (at_last) begin
                        instr_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                     end else begin
                        stage <= stage + 2'd1;
                     end
                  end
               end
            end
            default: begin
               state <= ERR;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboarded bench for stage_sequencer; watchdog expectations follow STAGE_SEQ_WATCHDOG_EN.
module tb_stage_sequencer;

`ifdef STAGE_SEQ_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] tp;
   logic [2:0] order_code;
   logic       order_valid;
   logic       order_ack;
   logic [1:0] stage;
   logic       busy;
   logic       rd_mem;
   logic       alu_strobe;
   logic       wr_mem;
   logic       instr_done;
   logic [7:0] mct_count;
   logic       tp_err;

   always #5 clk = ~clk;

   stage_sequencer #(.MCT_W(8), .WD_LIMIT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .tp          (tp),
      .order_code  (order_code),
      .order_valid (order_valid),
      .order_ack   (order_ack),
      .stage       (stage),
      .busy        (busy),
      .rd_mem      (rd_mem),
      .alu_strobe  (alu_strobe),
      .wr_mem      (wr_mem),
      .instr_done  (instr_done),
      .mct_count   (mct_count),
      .tp_err      (tp_err)
   );

   typedef struct {
      logic       ack;
      logic [1:0] stage;
      logic       busy;
      logic       rd;
      logic       alu;
      logic       wr;
      logic       done;
      logic [7:0] mct;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_ack = 0, cnt_rd = 0, cnt_alu = 0, cnt_wr = 0, cnt_done = 0;

   // Reference model of the instruction-level behaviour.
   int         n_tab [8] = '{1, 2, 1, 1, 2, 3, 4, 1};
   logic [7:0] wr_mask   = 8'b0011_1000;
   int         m_st;          // 0 idle, 1 run, 2 err
   logic [2:0] m_op;
   logic [1:0] m_stage;
   logic       m_busy;
   logic       m_err;
   logic [7:0] m_mct;
   int         m_wd;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_ack"},   order_ack,  0);
      check_val({tag, "_stage"}, stage,      0);
      check_val({tag, "_busy"},  busy,       0);
      check_val({tag, "_rd"},    rd_mem,     0);
      check_val({tag, "_alu"},   alu_strobe, 0);
      check_val({tag, "_wr"},    wr_mem,     0);
      check_val({tag, "_done"},  instr_done, 0);
      check_val({tag, "_mct"},   mct_count,  0);
      check_val({tag, "_err"},   tp_err,     0);
   endtask

   task automatic model_reset();
      m_st = 0; m_op = 0; m_stage = 0; m_busy = 0; m_err = 0; m_mct = 0; m_wd = 0;
   endtask

   // Drive one cycle of inputs and queue what the outputs must be after the next edge.
   task automatic step(input logic [9:0] t, input logic ov, input logic [2:0] oc);
      exp_t e;
      logic multi;
      logic [1:0] last;
      @(negedge clk);
      tp = t; order_valid = ov; order_code = oc;
      e.ack = 0; e.rd = 0; e.alu = 0; e.wr = 0; e.done = 0;
      multi = ($countones(t) > 1);
      if (m_st != 2 && t[9] && !multi) m_mct = m_mct + 8'd1;
      if (m_st == 0) begin
         m_wd = 0;
         if (multi) begin
            m_st = 2; m_err = 1; m_busy = 0;
         end else if (t[0] && ov) begin
            m_op = oc; e.ack = 1; m_stage = 0; m_busy = 1; m_st = 1;
         end
      end else if (m_st == 1) begin
         if (t == 10'd0) m_wd++; else m_wd = 0;
         if (multi || (WD_ON && m_wd >= 16)) begin
            m_st = 2; m_err = 1; m_busy = 0;
         end else begin
            last  = 2'(n_tab[m_op] - 1);
            e.rd  = t[1];
            e.alu = t[4];
            e.wr  = t[7] && wr_mask[m_op] && (m_stage == last);
            if (t[9]) begin
               if (m_stage == last) begin
                  e.done = 1; m_busy = 0; m_st = 0;
               end else begin
                  m_stage = m_stage + 2'd1;
               end
            end
         end
      end
      e.stage = m_stage; e.busy = m_busy; e.mct = m_mct; e.err = m_err;
      sb.push_back(e);
   endtask

   task automatic run_mct(input logic ov, input logic [2:0] oc);
      for (int k = 0; k < 10; k++) step(10'b1 << k, ov, oc);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; tp = 0;
      #1 check_zero("reset");
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         cnt_ack  += int'(order_ack);
         cnt_rd   += int'(rd_mem);
         cnt_alu  += int'(alu_strobe);
         cnt_wr   += int'(wr_mem);
         cnt_done += int'(instr_done);
      end
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check_val("ack",   order_ack,  mon_e.ack);
         check_val("stage", stage,      mon_e.stage);
         check_val("busy",  busy,       mon_e.busy);
         check_val("rd",    rd_mem,     mon_e.rd);
         check_val("alu",   alu_strobe, mon_e.alu);
         check_val("wr",    wr_mem,     mon_e.wr);
         check_val("done",  instr_done, mon_e.done);
         check_val("mct",   mct_count,  mon_e.mct);
         check_val("err",   tp_err,     mon_e.err);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      int a0, r0, al0, w0, d0;
      rst = 1; tp = 0; order_valid = 1; order_code = 0;
      model_reset();
      do_reset();

      // Opcode 0 with order_valid held from reset.
      step(10'd0, 1, 0);
      step(10'd0, 1, 0);
      a0 = cnt_ack; r0 = cnt_rd; al0 = cnt_alu; w0 = cnt_wr; d0 = cnt_done;
      run_mct(1, 0);
      settle();
      check_val("op0_mct",  mct_count, 1);
      check_val("op0_ack",  cnt_ack - a0, 1);
      check_val("op0_rd",   cnt_rd - r0, 1);
      check_val("op0_alu",  cnt_alu - al0, 1);
      check_val("op0_wr",   cnt_wr - w0, 0);
      check_val("op0_done", cnt_done - d0, 1);

      // Opcode 6 (four MCTs) then opcode 4 back-to-back.
      a0 = cnt_ack; w0 = cnt_wr; d0 = cnt_done;
      run_mct(1, 6);
      for (int i = 0; i < 3; i++) run_mct(1, 4);
      settle();
      check_val("op6_stage", stage, 3);
      check_val("op6_done",  cnt_done - d0, 1);
      check_val("op6_wr",    cnt_wr - w0, 0);
      run_mct(1, 4);
      run_mct(0, 4);
      settle();
      check_val("b2b_ack",  cnt_ack - a0, 2);
      check_val("b2b_wr",   cnt_wr - w0, 1);
      check_val("b2b_done", cnt_done - d0, 2);

      // Order raised at TP4 waits for the next TP1.
      a0 = cnt_ack; r0 = cnt_rd; al0 = cnt_alu; d0 = cnt_done;
      for (int k = 0; k < 3; k++) step(10'b1 << k, 0, 1);
      for (int k = 3; k < 10; k++) step(10'b1 << k, 1, 1);
      settle();
      check_val("late_ack", cnt_ack - a0, 0);
      check_val("late_rd",  cnt_rd - r0, 0);
      check_val("late_alu", cnt_alu - al0, 0);
      run_mct(1, 1);
      run_mct(0, 1);
      settle();
      check_val("late_ack2",  cnt_ack - a0, 1);
      check_val("late_done2", cnt_done - d0, 1);

      // Multi-hot timepulse in RUN is sticky until reset.
      step(10'b0000000001, 1, 2);
      step(10'b0000000010, 0, 2);
      step(10'b0000000110, 0, 2);
      settle();
      check_val("multi_err", tp_err, 1);
      a0 = cnt_ack; r0 = cnt_rd; al0 = cnt_alu; w0 = cnt_wr; d0 = cnt_done;
      for (int k = 3; k < 10; k++) step(10'b1 << k, 1, 2);
      step(10'b0000000001, 1, 2);
      step(10'b0000000010, 1, 2);
      settle();
      check_val("err_sticky", tp_err, 1);
      check_val("err_busy",   busy, 0);
      check_val("err_strobes", (cnt_ack - a0) + (cnt_rd - r0) + (cnt_alu - al0)
                               + (cnt_wr - w0) + (cnt_done - d0), 0);
      do_reset();

      // Reset during stage 1 TP6 of opcode 5.
      run_mct(1, 5);
      for (int k = 0; k < 5; k++) step(10'b1 << k, 0, 5);
      settle();
      check_val("op5_stage", stage, 1);
      @(negedge clk);
      tp = 10'b0000100000; rst = 1;
      #1 check_zero("rst_mid");
      model_reset();
      @(negedge clk);
      rst = 0; tp = 0;
      d0 = cnt_done;
      run_mct(1, 0);
      settle();
      check_val("restart_mct",  mct_count, 1);
      check_val("restart_done", cnt_done - d0, 1);

      // 256 single-MCT instructions wrap the MCT counter.
      do_reset();
      a0 = cnt_ack;
      for (int i = 0; i < 256; i++) run_mct(1, 7);
      settle();
      check_val("wrap_mct", mct_count, 0);
      check_val("wrap_ack", cnt_ack - a0, 256);

      // Stalled tp in RUN: watchdog trips only when built in.
      step(10'b0000000001, 1, 6);
      step(10'b0000000010, 0, 6);
      step(10'b0000000100, 0, 6);
      for (int i = 0; i < 20; i++) step(10'd0, 0, 6);
      settle();
      check_val("stall_err",  tp_err, WD_ON);
      check_val("stall_busy", busy, !WD_ON);

      check_val("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Consumes the one-hot timepulses TP1–TP10 produced by the sequence generator and turns them into instruction-level control. It latches an order code at TP1, counts memory cycle times (MCTs) per instruction, and emits one-cycle memory/ALU control strobes at fixed timepulses. It sits directly downstream of the sequence generator and upstream of the memory and ALU control logic.

## Interface
- `MCT_W`, default 8: width of the free-running MCT counter.
- `WD_LIMIT`, default 16: watchdog limit in clk cycles without a TP. Used only with `STAGE_SEQ_WATCHDOG_EN`.
- `clk` input 1: system clock; all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `tp` input 10: timepulses; bit i-1 = TPi; one-hot, each pulse one clk wide.
- `order_code` input 3: opcode of the next instruction.
- `order_valid` input 1: order_code is valid; held until `order_ack`.
- `order_ack` output 1: one-cycle pulse when the order is latched.
- `stage` output 2: current stage (MCT index within the instruction).
- `busy` output 1: an instruction is in progress.
- `rd_mem` output 1: memory read strobe.
- `alu_strobe` output 1: ALU strobe.
- `wr_mem` output 1: memory write-back strobe.
- `instr_done` output 1: one-cycle pulse at the end of the last MCT.
- `mct_count` output MCT_W: total TP10s seen; wraps.
- `tp_err` output 1: sticky timepulse error.

## Operation
- FSM states: IDLE, RUN, ERR.
- IDLE: on a sample with `tp[0]` (TP1) and `order_valid`:
  - latch `order_code`, pulse `order_ack`, set `stage` = 0, go to RUN.
  - A TP1 without `order_valid` stays in IDLE.
  - `order_valid` asserted outside TP1 waits for the next TP1.
- RUN, per MCT:
  - TP2 → `rd_mem` pulse.
  - TP5 → `alu_strobe` pulse.
  - TP8 → `wr_mem` pulse, only if `STG_WR[op]` = 1 and `stage` = last.
  - TP10 → if `stage` = `STG_N[op]`-1: pulse `instr_done`, go to IDLE. Otherwise `stage` += 1.
- Back-to-back instructions: IDLE samples the TP1 that immediately follows the final TP10. No MCT is lost.
- `mct_count` increments on every TP10 in any state except ERR. It wraps 2^MCT_W-1 → 0.
- Timepulse error: `tp` with more than one bit set, in any state → `tp_err` = 1, state ERR.
  - All strobes are held low in ERR.
  - ERR is left only by `rst`.
- `tp` = 0 is legal: a gap before the first pulse after reset.
- Order table (package):
  - `STG_N` per opcode: 0:1, 1:2, 2:1, 3:1, 4:2, 5:3, 6:4, 7:1.
  - `STG_WR` = 1 for opcodes 3, 4, 5.

## Timing
- All outputs are registered. A TP sampled at posedge N produces its strobe high for exactly cycle N+1.
- `order_ack` and the `stage` reset both appear at N+1 after TP1.
- `instr_done` coincides with the cycle after TP10.
- Reset values: state IDLE, `stage` 0, `busy` 0, all strobes 0, `mct_count` 0, `tp_err` 0.
- Reset asserted mid-instruction aborts immediately. No strobe is emitted after `rst` rises.

## Configuration
- Macro: `STAGE_SEQ_WATCHDOG_EN`.
- With the macro defined, in RUN:
  - count clk cycles since the last nonzero `tp`.
  - When the count reaches `WD_LIMIT`: set `tp_err` and go to ERR.
  - The counter clears on any TP and in IDLE.
- Without the macro: no counter logic, and a stalled `tp` leaves the block in RUN indefinitely.

## Structure
- Package `stage_seq_pkg`:
  - state enum.
  - `STG_N` and `STG_WR` tables as constant functions indexed by opcode.
  - TP bit-index constants (`TP1_B`=0 … `TP10_B`=9).
- One sub-module, `tp_checker`:
  - one-hot/zero check, producing `tp_multi`.
  - optional watchdog, producing `wd_expire`.
- Top level holds the FSM, stage counter and strobe registers.

## Test plan
- Opcode 0, `order_valid` held from reset, clean TP1–TP10 cycle:
  - `order_ack` cycle after TP1.
  - `rd_mem` after TP2, `alu_strobe` after TP5, no `wr_mem`.
  - `instr_done` after TP10, `mct_count`=1.
- Opcode 6 (4 MCTs) followed immediately by opcode 4:
  - `stage` 0→3.
  - One `instr_done` after the 4th TP10.
  - Second `order_ack` on the very next TP1.
  - `wr_mem` only in opcode 4's stage 1 after TP8.
- Order asserted at TP4: no ack until the next TP1; no strobes before it.
- `tp`=10'b0000000110 injected in RUN:
  - `tp_err`=1 next cycle, all strobes stay 0.
  - Further TPs ignored until `rst`.
- `rst` pulsed during stage 1 TP6 of opcode 5: all outputs 0 immediately; the next valid TP1 restarts cleanly.
- Run 256 MCTs → `mct_count` wraps to 0.
- With `STAGE_SEQ_WATCHDOG_EN` defined, `tp` held 0 for 16 cycles in RUN → `tp_err`=1.
